// File: rtl/ping_pkg.sv
// Shared definitions for the ping responder: state encodings, widths and
// default timing constants, also used by the Measure side and by benches.
package ping_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_HOLDOFF = 3'd2,
        ST_ECHO    = 3'd3,
        ST_GUARD   = 3'd4
    } ping_state_t;

    // Default timings in CLK cycles at 100 MHz.
    localparam int DEF_TRIG_MIN = 200;
    localparam int DEF_TRIG_MAX = 1000;
    localparam int DEF_HOLDOFF  = 75000;
    localparam int DEF_GUARD    = 20000;
    localparam int DEF_MAX_ECHO = 1000000;

    localparam int CNT_W = 21;
    localparam int LEN_W = 20;

    // True in the states where this block owns the shared line.
    function automatic logic drives_line(input ping_state_t s);
        return (s == ST_HOLDOFF) || (s == ST_ECHO) || (s == ST_GUARD);
    endfunction

endpackage

// File: rtl/sig_sync.sv
// Two-flop synchronizer for the shared Sig line with level, rise and fall
// outputs taken from the second flop.
module sig_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       s1_reg;
    logic       s2_reg;
    logic       prev_reg;
    logic       armed_reg;
    logic [1:0] fill_reg;

    // Edges are only reported once the line has been seen low after reset,
    // so a line already high when reset releases never looks like a trigger.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
            fill_reg  <= 2'd0;
        end else begin
            s1_reg   <= din;
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg;
            if (fill_reg != 2'd2) begin
                fill_reg <= fill_reg + 2'd1;
            end
            if ((fill_reg == 2'd2) && !s2_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign level = s2_reg;
    assign rise  = armed_reg & s2_reg & ~prev_reg;
    assign fall  = armed_reg & prev_reg & ~s2_reg;

endmodule

// File: rtl/ping_responder.sv
// Ultrasonic-style ping responder: validates a host trigger pulse on Sig,
// waits a holdoff, drives an echo pulse of programmable width, then guards.
module ping_responder
    import ping_pkg::*;
#(
    parameter int TRIG_MIN = DEF_TRIG_MIN,
    parameter int TRIG_MAX = DEF_TRIG_MAX,
    parameter int HOLDOFF  = DEF_HOLDOFF,
    parameter int GUARD    = DEF_GUARD,
    parameter int MAX_ECHO = DEF_MAX_ECHO
) (
    input  logic             CLK,
    input  logic             RESET,
    inout  wire              Sig,
    input  logic [LEN_W-1:0] ECHO_LEN,
    output logic             BUSY,
    output logic             TRIG_ERR,
    output logic [7:0]       TRIG_CNT
);

    localparam logic [CNT_W-1:0] MIN_W      = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(TRIG_MAX);
    localparam logic [CNT_W-1:0] SAT_W      = CNT_W'(TRIG_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [CNT_W-1:0] MAX_ECHO_W = CNT_W'(MAX_ECHO);

    ping_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] width_reg, width_next;
    logic [CNT_W-1:0] echo_len_reg, echo_len_next;
    logic [7:0]       trig_cnt_reg, trig_cnt_next;
    logic             trig_err_reg, trig_err_next;
    logic             sig_oe_reg, sig_oe_next;
    logic             sig_out_reg, sig_out_next;

    logic sig_level;
    logic sig_rise;
    logic sig_fall;

    sig_sync u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (Sig),
        .level (sig_level),
        .rise  (sig_rise),
        .fall  (sig_fall)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            width_reg    <= '0;
            echo_len_reg <= '0;
            trig_cnt_reg <= 8'd0;
            trig_err_reg <= 1'b0;
            sig_oe_reg   <= 1'b0;
            sig_out_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            width_reg    <= width_next;
            echo_len_reg <= echo_len_next;
            trig_cnt_reg <= trig_cnt_next;
            trig_err_reg <= trig_err_next;
            sig_oe_reg   <= sig_oe_next;
            sig_out_reg  <= sig_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        width_next    = width_reg;
        echo_len_next = echo_len_reg;
        trig_cnt_next = trig_cnt_reg;
        trig_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sig_rise) begin
                    state_next = ST_TRIG;
                    width_next = CNT_W'(1);
                end
            end

            // Width counts synchronized high samples; a stuck-high line just
            // parks here with the counter saturated one past the limit.
            ST_TRIG: begin
                if (sig_fall) begin
                    if ((width_reg >= MIN_W) && (width_reg <= MAX_W)) begin
                        state_next    = ST_HOLDOFF;
                        cnt_next      = '0;
                        echo_len_next = (ECHO_LEN == '0) ? MAX_ECHO_W
                                                         : CNT_W'(ECHO_LEN);
                        trig_cnt_next = trig_cnt_reg + 8'd1;
                    end else begin
                        state_next    = ST_IDLE;
                        trig_err_next = 1'b1;
                    end
                end else if (sig_level && (width_reg != SAT_W)) begin
                    width_next = width_reg + CNT_W'(1);
                end
            end

            ST_HOLDOFF: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_ECHO;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_ECHO: begin
                if (cnt_reg == (echo_len_reg - CNT_W'(1))) begin
                    state_next = ST_GUARD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_GUARD: begin
                if (cnt_reg == GUARD_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Drive is registered from the next state so it switches on the same
        // edge as the state register.
        sig_oe_next  = drives_line(state_next);
        sig_out_next = (state_next == ST_ECHO);
    end

    assign Sig      = sig_oe_reg ? sig_out_reg : 1'bz;
    assign BUSY     = (state_reg != ST_IDLE);
    assign TRIG_ERR = trig_err_reg;
    assign TRIG_CNT = trig_cnt_reg;

endmodule

// File: doc/ping_responder.md
PING_RESPONDER -- requirements
Module: ping_responder

Interface
REQ-001 Parameter TRIG_MIN, default 200: minimum accepted trigger high width, in CLK cycles (2 us at 100 MHz).
REQ-002 Parameter TRIG_MAX, default 1000: maximum accepted trigger high width, in CLK cycles.
REQ-003 Parameter HOLDOFF, default 75000: cycles from trigger acceptance to echo start (750 us).
REQ-004 Parameter GUARD, default 20000: cycles after echo end before re-arm.
REQ-005 Parameter MAX_ECHO, default 1000000: echo width used when ECHO_LEN is 0, meaning no target.
REQ-006 Port CLK, input, 1: the single clock; all logic is on its rising edge.
REQ-007 Port RESET, input, 1: synchronous, active-low reset.
REQ-008 Port Sig, inout, 1: shared trigger/echo line; the host drives the trigger and this block drives the echo.
REQ-009 Port ECHO_LEN, input, 20: echo high width in CLK cycles for the next measurement.
REQ-010 Port BUSY, output, 1: high in every state except IDLE.
REQ-011 Port TRIG_ERR, output, 1: one-cycle pulse when a trigger is rejected.
REQ-012 Port TRIG_CNT, output, 8: count of accepted triggers; wraps 255->0.

Function
REQ-013 Sig SHALL be sampled through a two-flop synchronizer; all edge decisions use the second flop (2-cycle input latency).
REQ-014 The state machine SHALL have five states: IDLE, TRIG, HOLDOFF, ECHO, GUARD.
REQ-015 IDLE->TRIG on a synchronized rising edge of Sig; the width counter is cleared to 1.
REQ-016 In TRIG the width counter SHALL increment each cycle while Sig is high and saturate at TRIG_MAX+1.
REQ-017 On a falling edge in TRIG with TRIG_MIN <= width <= TRIG_MAX the block SHALL accept the trigger:
  - latch ECHO_LEN (MAX_ECHO if 0);
  - increment TRIG_CNT;
  - enter HOLDOFF.
REQ-018 On a falling edge in TRIG with width outside that range the block SHALL pulse TRIG_ERR for one cycle and return to IDLE.
REQ-019 Sig held high indefinitely SHALL keep the block in TRIG; there is no timeout.
REQ-020 HOLDOFF SHALL last exactly HOLDOFF cycles, then go to ECHO.
REQ-021 ECHO SHALL drive Sig high from a registered output enable for exactly the latched width, then go to GUARD.
REQ-022 GUARD SHALL last exactly GUARD cycles, then go to IDLE.
REQ-023 Sig drive per state:
  - 0 in HOLDOFF and GUARD;
  - 1 in ECHO;
  - high-Z in IDLE and TRIG.
REQ-024 Sig activity outside IDLE and TRIG SHALL be ignored (no re-trigger, no error).
REQ-025 ECHO_LEN changes after acceptance SHALL NOT affect the echo in progress.
REQ-026 State counters SHALL be 21 bits wide, enough for MAX_ECHO and HOLDOFF without overflow.

Reset
REQ-027 While RESET is low at a CLK edge:
  - state = IDLE;
  - Sig = high-Z;
  - BUSY = 0, TRIG_ERR = 0, TRIG_CNT = 0;
  - synchronizer flops = 0.
REQ-028 Reset asserted mid-echo SHALL release Sig to high-Z on the next CLK edge.
REQ-029 After reset deasserts, a Sig already high SHALL NOT count as a rising edge; a fresh low->high transition is required.

Structure
REQ-030 Shared package ping_pkg SHALL hold the state encodings and the default timing constants for reuse by the Measure side and by benches.
REQ-031 Synchronizer plus edge detect SHALL be one sub-module, sig_sync (outputs: level, rise, fall).
REQ-032 The FSM, counters and tristate driver SHALL live in ping_responder.

Verification
REQ-033 Trigger width 500, ECHO_LEN 40000 -> Sig low for 75000 cycles, then high for exactly 40000, low for 20000, then high-Z; TRIG_CNT = 1.
REQ-034 Trigger widths 199 and 1001 -> one TRIG_ERR pulse each, no echo, TRIG_CNT unchanged; widths 200 and 1000 are accepted.
REQ-035 ECHO_LEN 0 -> echo high for 1000000 cycles.
REQ-036 Trigger pulse injected during HOLDOFF, ECHO and GUARD -> no effect on echo timing, no TRIG_ERR.
REQ-037 RESET low for one cycle at echo cycle 100 -> Sig high-Z next cycle, BUSY 0, TRIG_CNT 0; with Sig held high after reset -> no trigger until low then high.
REQ-038 256 accepted triggers -> TRIG_CNT wraps to 0.
